// File: rtl/stereo_ringbuf_bank.sv
// stereo_ringbuf_bank: per-channel L/R sample rings feeding the mixer pop/ack interface
//
// Holds NUM_CH stereo streams, one DEPTH-entry ring per side (side 2k = L, 2k+1 = R).
// Each side primes until PREFILL samples are buffered, reports its fill level, drops
// the oldest sample on overrun and flags underrun; both flags are sticky until clr_i.
//
// Ports:
//   clk245760   clock
//   rst         synchronous active-high reset (pointers/levels/flags, not ring contents)
//   data_i      per-channel input sample, channel k at [k*WIDTH +: WIDTH]
//   ack_i       per-channel write strobe
//   lrck_i      per-channel side select at write (1 = left, 0 = right)
//   pop_i       per-side read request
//   clr_i       clears all sticky flags
//   data_o      per-channel output sample, zero unless one of its sides is acked
//   ack_o       per-side read acknowledge, one clock after the serviced pop
//   level_o     per-side fill level 0..DEPTH, DEPTH_LOG2+1 bits each
//   underrun_o  sticky per-side underrun flag
//   overrun_o   sticky per-side overrun flag
//
// Optional: define RINGBUF_HOLD_ON_UNDERRUN_EN to replay the last delivered sample
// instead of zero while priming or underrunning.
module stereo_ringbuf_bank #(
    parameter int NUM_CH     = 1,
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8
) (
    input  logic                                 clk245760,
    input  logic                                 rst,
    input  logic [NUM_CH*WIDTH-1:0]              data_i,
    input  logic [NUM_CH-1:0]                    ack_i,
    input  logic [NUM_CH-1:0]                    lrck_i,
    input  logic [2*NUM_CH-1:0]                  pop_i,
    input  logic                                 clr_i,
    output logic [NUM_CH*WIDTH-1:0]              data_o,
    output logic [2*NUM_CH-1:0]                  ack_o,
    output logic [2*NUM_CH*(DEPTH_LOG2+1)-1:0]   level_o,
    output logic [2*NUM_CH-1:0]                  underrun_o,
    output logic [2*NUM_CH-1:0]                  overrun_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NS    = 2 * NUM_CH;
    localparam int LW    = DEPTH_LOG2 + 1;

    generate
        if (PREFILL < 1 || PREFILL > DEPTH) begin : g_bad_prefill
            $error("stereo_ringbuf_bank: PREFILL must be within 1..DEPTH");
        end
    endgenerate

    typedef enum logic {PRIME, RUN} state_t;

    state_t                r_state [NS];
    logic [DEPTH_LOG2-1:0] r_wptr  [NS];
    logic [DEPTH_LOG2-1:0] r_rptr  [NS];
    logic [LW-1:0]         r_level [NS];
    logic [WIDTH-1:0]      r_mem   [NS][DEPTH];
    logic [WIDTH-1:0]      r_data  [NUM_CH];
    logic [NS-1:0]         r_ack, r_under, r_over;
    logic [NUM_CH-1:0]     r_pend;
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
    logic [WIDTH-1:0]      r_last  [NS];
`endif

    logic [NS-1:0]         w_srv, w_wr, w_rd, w_ur, w_ov;
    logic [NUM_CH-1:0]     w_pend_n;
    logic [WIDTH-1:0]      w_out   [NS];

    always_comb begin
        w_srv    = '0;
        w_pend_n = '0;
        w_wr     = '0;
        w_rd     = '0;
        w_ur     = '0;
        w_ov     = '0;
        // L always wins the shared data_o; a colliding or pending R waits a clock
        for (int k = 0; k < NUM_CH; k++) begin
            w_srv[2*k]   = pop_i[2*k];
            w_srv[2*k+1] = (pop_i[2*k+1] | r_pend[k]) & ~pop_i[2*k];
            w_pend_n[k]  = pop_i[2*k] & (pop_i[2*k+1] | r_pend[k]);
        end
        for (int s = 0; s < NS; s++) begin
            w_wr[s] = ack_i[s/2] & (lrck_i[s/2] == (s % 2 == 0));
            w_rd[s] = w_srv[s] & (r_state[s] == RUN) & (r_level[s] != '0);
            w_ur[s] = w_srv[s] & (r_state[s] == RUN) & (r_level[s] == '0);
            // a consuming pop frees the slot, so only an unpaired write at full overruns
            w_ov[s] = w_wr[s] & ~w_rd[s] & (r_level[s] == LW'(DEPTH));
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
            w_out[s] = w_rd[s] ? r_mem[s][r_rptr[s]] : r_last[s];
`else
            w_out[s] = w_rd[s] ? r_mem[s][r_rptr[s]] : '0;
`endif
        end
    end

    always_ff @(posedge clk245760) begin
        // ring storage is read before this edge's write, giving read-before-write at full
        for (int s = 0; s < NS; s++)
            if (w_wr[s]) r_mem[s][r_wptr[s]] <= data_i[(s/2)*WIDTH +: WIDTH];
        if (rst) begin
            r_ack   <= '0;
            r_under <= '0;
            r_over  <= '0;
            r_pend  <= '0;
            for (int s = 0; s < NS; s++) begin
                r_state[s] <= PRIME;
                r_wptr[s]  <= '0;
                r_rptr[s]  <= '0;
                r_level[s] <= '0;
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
                r_last[s]  <= '0;
`endif
            end
            for (int k = 0; k < NUM_CH; k++) r_data[k] <= '0;
        end else begin
            r_ack   <= w_srv;
            r_pend  <= w_pend_n;
            r_under <= (r_under & ~{NS{clr_i}}) | w_ur;
            r_over  <= (r_over & ~{NS{clr_i}}) | w_ov;
            for (int s = 0; s < NS; s++) begin
                if (w_wr[s]) r_wptr[s] <= r_wptr[s] + 1'b1;
                if (w_rd[s] || w_ov[s]) r_rptr[s] <= r_rptr[s] + 1'b1;
                r_level[s] <= (w_wr[s] && !w_rd[s] && !w_ov[s]) ? r_level[s] + 1'b1 :
                              (!w_wr[s] && w_rd[s]) ? r_level[s] - 1'b1 : r_level[s];
                r_state[s] <= w_ur[s] ? PRIME :
                              (r_state[s] == PRIME && r_level[s] >= LW'(PREFILL)) ? RUN : r_state[s];
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
                if (w_rd[s]) r_last[s] <= w_out[s];
`endif
            end
            for (int k = 0; k < NUM_CH; k++)
                r_data[k] <= w_srv[2*k] ? w_out[2*k] : w_srv[2*k+1] ? w_out[2*k+1] : '0;
        end
    end

    always_comb begin
        data_o  = '0;
        level_o = '0;
        for (int k = 0; k < NUM_CH; k++) data_o[k*WIDTH +: WIDTH] = r_data[k];
        for (int s = 0; s < NS; s++) level_o[s*LW +: LW] = r_level[s];
    end

    assign ack_o      = r_ack;
    assign underrun_o = r_under;
    assign overrun_o  = r_over;
endmodule

// File: tb/tb_stereo_ringbuf_bank.sv
// tb_stereo_ringbuf_bank: directed and random stimulus against a queue-based reference model
module tb_stereo_ringbuf_bank;
    localparam int NCH = 2;
    localparam int W   = 24;
    localparam int DL  = 4;
    localparam int D   = 16;
    localparam int PF  = 8;
    localparam int NS  = 2 * NCH;
    localparam int LW  = DL + 1;

    logic                clk245760 = 1'b0;
    logic                rst = 1'b1;
    logic                clr_i = 1'b0;
    logic [NCH*W-1:0]    data_i = '0;
    logic [NCH-1:0]      ack_i = '0;
    logic [NCH-1:0]      lrck_i = '0;
    logic [NS-1:0]       pop_i = '0;
    logic [NCH*W-1:0]    data_o;
    logic [NS-1:0]       ack_o;
    logic [NS*LW-1:0]    level_o;
    logic [NS-1:0]       underrun_o;
    logic [NS-1:0]       overrun_o;

    stereo_ringbuf_bank #(.NUM_CH(NCH), .WIDTH(W), .DEPTH_LOG2(DL), .PREFILL(PF)) dut (
        .clk245760(clk245760), .rst(rst), .data_i(data_i), .ack_i(ack_i), .lrck_i(lrck_i),
        .pop_i(pop_i), .clr_i(clr_i), .data_o(data_o), .ack_o(ack_o), .level_o(level_o),
        .underrun_o(underrun_o), .overrun_o(overrun_o)
    );

    always #5 clk245760 = ~clk245760;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: one FIFO queue per side plus running/flag bits
    int q[NS][$];
    bit run[NS];
    bit uf[NS];
    bit of[NS];
    bit pend[NCH];
    int last[NS];
    logic [NS-1:0]    e_ack;
    logic [NCH*W-1:0] e_data;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mute(int s);
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
        return last[s];
`else
        return 0;
`endif
    endfunction

    task automatic serve(int s, output int d);
        if (!run[s]) d = mute(s);
        else if (q[s].size() == 0) begin
            uf[s] = 1'b1;
            run[s] = 1'b0;
            d = mute(s);
        end else begin
            d = q[s].pop_front();
            last[s] = d;
        end
    endtask

    task automatic model_step();
        int  old_sz[NS];
        bit  was_run[NS];
        int  d;
        int  s;
        bit  rl, rr;
        e_ack = '0;
        e_data = '0;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                q[i].delete();
                run[i] = 0; uf[i] = 0; of[i] = 0; last[i] = 0;
            end
            for (int k = 0; k < NCH; k++) pend[k] = 0;
            return;
        end
        if (clr_i) for (int i = 0; i < NS; i++) begin uf[i] = 0; of[i] = 0; end
        for (int i = 0; i < NS; i++) begin old_sz[i] = q[i].size(); was_run[i] = run[i]; end
        for (int k = 0; k < NCH; k++) begin
            rl = pop_i[2*k];
            rr = pop_i[2*k+1] | pend[k];
            pend[k] = rl & rr;
            s = rl ? 2*k : (rr ? 2*k+1 : -1);
            if (s >= 0) begin
                serve(s, d);
                e_ack[s] = 1'b1;
                e_data[k*W +: W] = d[W-1:0];
            end
        end
        for (int k = 0; k < NCH; k++) if (ack_i[k]) begin
            s = lrck_i[k] ? 2*k : 2*k+1;
            if (q[s].size() == D) begin
                void'(q[s].pop_front());
                of[s] = 1'b1;
            end
            q[s].push_back(int'(data_i[k*W +: W]));
        end
        for (int i = 0; i < NS; i++) if (!was_run[i] && old_sz[i] >= PF) run[i] = 1'b1;
    endtask

    task automatic cyc();
        logic [NS*LW-1:0] e_lvl;
        logic [NS-1:0]    e_uf, e_of;
        model_step();
        @(posedge clk245760);
        #1;
        for (int i = 0; i < NS; i++) begin
            e_lvl[i*LW +: LW] = LW'(q[i].size());
            e_uf[i] = uf[i];
            e_of[i] = of[i];
        end
        chk("ack", ack_o, e_ack);
        chk("data", data_o, e_data);
        chk("level", level_o, e_lvl);
        chk("underrun", underrun_o, e_uf);
        chk("overrun", overrun_o, e_of);
    endtask

    task automatic put(int s, int v, logic [NS-1:0] p);
        ack_i = '0;
        ack_i[s/2] = 1'b1;
        lrck_i[s/2] = (s % 2 == 0);
        data_i[(s/2)*W +: W] = v[W-1:0];
        pop_i = p;
        cyc();
        ack_i = '0;
        pop_i = '0;
    endtask

    task automatic pop(logic [NS-1:0] p);
        pop_i = p;
        cyc();
        pop_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int mute_exp;
`ifdef RINGBUF_HOLD_ON_UNDERRUN_EN
        mute_exp = 'hABCDEF;
`else
        mute_exp = 0;
`endif
        do_reset();
        chk("rst_level", level_o, 0);
        chk("rst_ack", ack_o, 0);

        // priming: writes 1..8 with a pop every 4 clocks
        for (int i = 1; i <= 8; i++) put(0, i, (i % 4 == 0) ? 4'b0001 : 4'b0000);
        pop(4'b0001);
        chk("prime_ack", ack_o[0], 1);
        chk("prime_mute", data_o[W-1:0], 0);
        pop(4'b0001);
        chk("first_run", data_o[W-1:0], 1);
        chk("first_lvl", level_o[LW-1:0], 7);

        // overrun drops the oldest
        do_reset();
        for (int i = 1; i <= 16; i++) put(0, i, 4'b0000);
        put(0, 'hABCDEF, 4'b0000);
        chk("ovr_flag", overrun_o[0], 1);
        chk("ovr_lvl", level_o[LW-1:0], 16);
        pop(4'b0001);
        chk("ovr_next", data_o[W-1:0], 2);

        // drain, then underrun
        repeat (15) pop(4'b0001);
        chk("drained", level_o[LW-1:0], 0);
        pop(4'b0001);
        chk("ur_ack", ack_o[0], 1);
        chk("ur_data", data_o[W-1:0], mute_exp);
        chk("ur_flag", underrun_o[0], 1);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        chk("ur_clr", underrun_o[0], 0);

        // simultaneous L/R pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put(0, (i == 0) ? 'h111111 : i, 4'b0000);
            put(1, (i == 0) ? 'h222222 : 100 + i, 4'b0000);
        end
        cyc();
        pop(4'b0011);
        chk("lr_ack1", ack_o, 4'b0001);
        chk("lr_dat1", data_o[W-1:0], 'h111111);
        cyc();
        chk("lr_ack2", ack_o, 4'b0010);
        chk("lr_dat2", data_o[W-1:0], 'h222222);

        // full with same-cycle write and pop
        for (int i = 0; i < 9; i++) put(0, 200 + i, 4'b0000);
        chk("full_lvl", level_o[LW-1:0], 16);
        put(0, 'h555, 4'b0001);
        chk("full_rw_dat", data_o[W-1:0], 1);
        chk("full_rw_lvl", level_o[LW-1:0], 16);
        chk("full_rw_ovr", overrun_o[0], 0);

        // traffic on channel 1 only
        for (int i = 0; i < 10; i++) put(2 + (i % 2), 300 + i, (i > 4) ? 4'b0100 : 4'b0000);
        chk("indep_ch0", level_o[2*LW-1:0], {LW'(q[1].size()), LW'(q[0].size())});

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int wp;
            wp = ((n / 300) % 2) ? 80 : 30;
            rst = ($urandom_range(0, 599) == 0);
            clr_i = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NCH; k++) begin
                ack_i[k] = ($urandom_range(0, 99) < wp);
                lrck_i[k] = $urandom_range(0, 1);
                data_i[k*W +: W] = W'($urandom);
                pop_i[2*k] = !pend[k] && ($urandom_range(0, 99) < 25);
                pop_i[2*k+1] = ($urandom_range(0, 99) < 25);
            end
            cyc();
        end
        rst = 1'b0;
        clr_i = 1'b0;
        ack_i = '0;
        pop_i = '0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stereo_ringbuf_bank.md
Name: stereo_ringbuf_bank

Overview:
- Parametrised replacement for the per-input L/R ring buffer pair and its pop/ack glue between the S/PDIF receivers and the mixer.
- Holds NUM_CH stereo streams, each side in its own DEPTH-entry ring, all in the clk245760 domain.
- Adds prefill priming, fill-level reporting, overrun drop-oldest, and underrun detection with sticky status.
- Output side speaks the mixer's pop/ack protocol: ack and data arrive exactly 1 clk after pop.

Parameters:
- NUM_CH, 1: number of stereo input streams.
- WIDTH, 24: sample width in bits.
- DEPTH_LOG2, 4: log2 of ring depth per side (DEPTH = 2**DEPTH_LOG2).
- PREFILL, 8: level a side must reach before leaving PRIME. Legal range 1..DEPTH; out-of-range values must cause an elaboration error.

Ports:
- clk245760, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- data_i, in, NUM_CH*WIDTH: per-channel input sample; channel k occupies bits [k*WIDTH +: WIDTH].
- ack_i, in, NUM_CH: per-channel 1-clk write strobe; data_i and lrck_i are valid in that cycle.
- lrck_i, in, NUM_CH: side select at write. 1 = left, written to side index 2k; 0 = right, written to side index 2k+1.
- pop_i, in, 2*NUM_CH: read request per side; bit 2k = L, bit 2k+1 = R.
- data_o, out, NUM_CH*WIDTH: per-channel output sample; valid only while that channel's ack_o bit is high, zero otherwise.
- ack_o, out, 2*NUM_CH: per-side read acknowledge.
- level_o, out, 2*NUM_CH*(DEPTH_LOG2+1): per-side fill level, 0..DEPTH.
- underrun_o, out, 2*NUM_CH: sticky per-side underrun flag.
- overrun_o, out, 2*NUM_CH: sticky per-side overrun flag.
- clr_i, in, 1: 1-clk pulse that clears all sticky flags.

Behaviour:
- Reset (synchronous, rst=1):
  - all pointers and levels go to 0; every side enters PRIME.
  - ack_o=0, data_o=0, level_o=0, flags=0, pending-R=0.
  - ring contents are not cleared.
  - rst asserted mid-operation discards all buffered data; the first pop after rst deasserts gets a mute ack.
- Write: on ack_i[k], store data_i[k] into side 2k (lrck_i=1) or side 2k+1 (lrck_i=0) at wptr; wptr increments modulo DEPTH.
- Side state machine, two states:
  - PRIME: each pop is acked 1 clk later with mute data; rptr does not move. Go to RUN in the cycle after level >= PREFILL.
  - RUN: each pop is acked 1 clk later with ring[rptr]; rptr increments; level decrements.
- Underrun: pop in RUN with level==0 (evaluated before any same-cycle write).
  - ack is still asserted, with mute data.
  - underrun flag set; side returns to PRIME.
  - a same-cycle write is still stored, so level becomes 1.
- Overrun: write with level==DEPTH and no same-cycle pop.
  - write proceeds; rptr advances (oldest sample dropped); level stays DEPTH; overrun flag set.
- Full with write and pop in the same cycle: the pop returns the oldest sample (read-before-write at the shared address), then the write lands. Level stays DEPTH; no flag.
- Write and pop in the same cycle, not empty and not full: level is unchanged.
- Simultaneous pop of L and R on one channel (shared data_o):
  - L is acked at +1 clk; R is latched as pending and acked at +2 clk.
  - The R read uses rptr/level as of the R service cycle.
  - A new R pop while R is already pending merges with it; no extra ack is generated.
- Mute data = 0.
- Flags: clr_i clears all sticky flags. If a set event and clr_i fall in the same cycle, the set wins.
- Level arithmetic is DEPTH_LOG2+1 bits wide and never wraps.

Optional Feature:
- Macro: RINGBUF_HOLD_ON_UNDERRUN_EN.
- Defined: mute data is the last sample actually delivered on that side (0 if none has been delivered since reset), so underruns and priming repeat the previous value instead of clicking.
- Undefined: mute data = 0.

Test Plan:
- NUM_CH=1, PREFILL=8. Write L samples 1..8, popping L every 4 clk throughout -> acks with data 0 until 1 clk after level reaches 8; next ack returns 1; level_o decrements from there.
- Fill L to 16 (DEPTH=16), then write 0xABCDEF with no pop -> overrun_o[0]=1, level stays 16, next RUN pop returns sample 2.
- Drain L to 0 in RUN, then pop -> ack with data 0, underrun_o[0]=1, side in PRIME. Pulse clr_i -> flag cleared.
- pop_i=2'b11 with L=0x111111 and R=0x222222 at the buffer heads -> cycle+1: ack_o=01, data 0x111111; cycle+2: ack_o=10, data 0x222222.
- Full L with write and pop in the same cycle -> ack returns the oldest sample, level stays 16, no overrun flag.
- Repeat the underrun case with RINGBUF_HOLD_ON_UNDERRUN_EN defined, last delivered sample 0x00F00D -> underrun ack data 0x00F00D. NUM_CH=3 independence check: traffic on channel 1 leaves channels 0 and 2 levels unchanged.
